mem_arbiter: RTL and testbench

// Shares the single data-memory port between the IFU (read-only) and the LSU (read/write).

---
 rtl/npc_mem_pkg.sv | 41 ++++
 rtl/mem_arbiter_rr_arb2.sv | 26 ++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_mem_pkg.sv
// ============================================================================
// Module   : npc_mem_pkg
// Purpose  : Shared types, width-op encodings and alignment check for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package npc_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      GNT_IFU = 1'b0,
      GNT_LSU = 1'b1
   } grant_t;

   localparam logic [1:0] c_WDT8  = 2'd0;
   localparam logic [1:0] c_WDT16 = 2'd1;
   localparam logic [1:0] c_WDT32 = 2'd2;
   localparam logic [1:0] c_WDT64 = 2'd3;

   function automatic logic f_misaligned(input logic [2:0] i_addr_lo, input logic [1:0] i_wdt);
      logic r_bad;
      r_bad = 1'b0;
      case (i_wdt)
         c_WDT16: r_bad = i_addr_lo[0];
         c_WDT32: r_bad = |i_addr_lo[1:0];
         c_WDT64: r_bad = |i_addr_lo[2:0];
         default: r_bad = 1'b0;
      endcase
      return r_bad;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin grant; on conflict the side that did not win last time wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
   import npc_mem_pkg::*;
(
   input  logic [1:0] i_req,
   input  grant_t     i_last,
   output logic [1:0] o_gnt
);

   // bit 0 = IFU, bit 1 = LSU
   always_comb begin
      o_gnt = i_req;
      if (&i_req) begin
         o_gnt = (i_last == GNT_IFU) ? 2'b10 : 2'b01;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one data-memory port between IFU (read-only) and LSU (read/write).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
   import npc_mem_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int WDT_W  = 2,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic              lsu_wen,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [WDT_W-1:0]  lsu_wdt,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [WDT_W-1:0]  mem_wdt,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              misalign
);

   localparam int               CNT_W       = $clog2(LAT + 1);
   localparam logic [CNT_W-1:0] c_WAIT_INIT = CNT_W'(LAT - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

   arb_state_t        r_state;
   arb_state_t        w_next;
   grant_t            r_last;
   grant_t            r_owner;
   logic              r_wen;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [WDT_W-1:0]  r_wdt;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        w_gnt;
   logic              w_hs_ifu;
   logic              w_hs_lsu;

   rr_arb2 u_rr_arb2 (
      .i_req  ({lsu_req_valid, ifu_req_valid}),
      .i_last (r_last),
      .o_gnt  (w_gnt)
   );

   assign w_hs_ifu = ifu_req_valid & ifu_req_ready;
   assign w_hs_lsu = lsu_req_valid & lsu_req_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Request latch, last-grant and latency counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last  <= GNT_IFU;
         r_owner <= GNT_IFU;
         r_wen   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wdt   <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_hs_lsu) begin
            r_last  <= GNT_LSU;
            r_owner <= GNT_LSU;
            r_wen   <= lsu_wen;
            r_addr  <= lsu_addr;
            r_wdata <= lsu_wdata;
            r_wdt   <= lsu_wdt;
         end else if (w_hs_ifu) begin
            r_last  <= GNT_IFU;
            r_owner <= GNT_IFU;
            r_wen   <= 1'b0;
            r_addr  <= ifu_addr;
            r_wdata <= '0;
            r_wdt   <= WDT_W'(c_WDT32);
         end
         if (r_state == ISSUE) begin
            r_cnt <= c_WAIT_INIT;
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - c_CNT_ONE;
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_hs_ifu || w_hs_lsu) w_next = ISSUE;
         ISSUE:   w_next = (LAT == 1) ? RESP : WAIT;
         WAIT:    if (r_cnt == c_CNT_ONE) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs: memory strobes only in ISSUE, response only in RESP
   always_comb begin
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      ifu_rdata      = '0;
      lsu_rdata      = '0;
      mem_ren        = 1'b0;
      mem_wen        = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      mem_wdt        = '0;
      misalign       = 1'b0;
      case (r_state)
         IDLE: begin
            ifu_req_ready = w_gnt[0];
            lsu_req_ready = w_gnt[1];
         end
         ISSUE: begin
            mem_ren   = ~r_wen;
            mem_wen   = r_wen;
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
            mem_wdt   = r_wdt;
            misalign  = f_misaligned(r_addr[2:0], r_wdt[1:0]);
         end
         RESP: begin
            if (r_owner == GNT_LSU) begin
               lsu_resp_valid = 1'b1;
               lsu_rdata      = r_wen ? '0 : mem_rdata;
            end else begin
               ifu_resp_valid = 1'b1;
               ifu_rdata      = mem_rdata;
            end
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter at LAT=1 and LAT=3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n, rst3_n;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
   logic [63:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
   logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [1:0]  lsu_wdt, mem_wdt;
   logic        mem_ren, mem_wen, misalign;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;

   logic        ifu_req_valid3, ifu_req_ready3, ifu_resp_valid3;
   logic [63:0] ifu_addr3, ifu_rdata3;
   logic        lsu_req_ready3, lsu_resp_valid3;
   logic [63:0] lsu_rdata3;
   logic [1:0]  mem_wdt3;
   logic        mem_ren3, mem_wen3, misalign3;
   logic [63:0] mem_addr3, mem_wdata3, mem_rdata3;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        owner;
      logic [63:0] rdata;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .WDT_W(2), .LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wdt(lsu_wdt),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wdt(mem_wdt), .mem_rdata(mem_rdata), .misalign(misalign)
   );

   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .WDT_W(2), .LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst3_n),
      .ifu_req_valid(ifu_req_valid3), .ifu_req_ready(ifu_req_ready3), .ifu_addr(ifu_addr3),
      .ifu_resp_valid(ifu_resp_valid3), .ifu_rdata(ifu_rdata3),
      .lsu_req_valid(1'b0), .lsu_req_ready(lsu_req_ready3), .lsu_wen(1'b0),
      .lsu_addr(64'd0), .lsu_wdata(64'd0), .lsu_wdt(2'd0),
      .lsu_resp_valid(lsu_resp_valid3), .lsu_rdata(lsu_rdata3),
      .mem_ren(mem_ren3), .mem_wen(mem_wen3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
      .mem_wdt(mem_wdt3), .mem_rdata(mem_rdata3), .misalign(misalign3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic owner, input logic [63:0] rdata);
      exp_t e;
      e.owner = owner;
      e.rdata = rdata;
      sb.push_back(e);
   endtask

   // Called in the cycle the response is due; pops the oldest expectation.
   task automatic resp_chk(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_vld"}, e.owner ? lsu_resp_valid : ifu_resp_valid, 64'd1);
         chk({tag, "_other"}, e.owner ? ifu_resp_valid : lsu_resp_valid, 64'd0);
         chk({tag, "_rdata"}, e.owner ? lsu_rdata : ifu_rdata, e.rdata);
      end
   endtask

   logic [63:0] tab_addr [5] = '{64'h8000_0001, 64'h8000_0003, 64'h8000_0002, 64'h8000_0006, 64'h8000_0008};
   logic [1:0]  tab_wdt  [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
   logic        tab_mis  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 0; rst3_n = 0;
      ifu_req_valid = 0; ifu_addr = 0; lsu_req_valid = 0; lsu_wen = 0;
      lsu_addr = 0; lsu_wdata = 0; lsu_wdt = 0; mem_rdata = 0;
      ifu_req_valid3 = 0; ifu_addr3 = 0; mem_rdata3 = 0;
      tick(); tick();
      chk("rst_ren", mem_ren, 0);
      chk("rst_wen", mem_wen, 0);
      chk("rst_ifu_resp", ifu_resp_valid, 0);
      chk("rst_lsu_resp", lsu_resp_valid, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_misalign", misalign, 0);
      rst_n = 1; rst3_n = 1;
      tick();

      // 1: IFU-only read
      mem_rdata = 64'h0000_0000_1234_5678;
      ifu_req_valid = 1; ifu_addr = 64'h8000_0000;
      #1;
      chk("t1_ifu_rdy", ifu_req_ready, 1);
      chk("t1_lsu_rdy", lsu_req_ready, 0);
      push(1'b0, 64'h0000_0000_1234_5678);
      tick();
      ifu_req_valid = 0;
      chk("t1_ren", mem_ren, 1);
      chk("t1_wen", mem_wen, 0);
      chk("t1_addr", mem_addr, 64'h8000_0000);
      chk("t1_wdt", mem_wdt, 2);
      chk("t1_rdy_busy", ifu_req_ready, 0);
      tick();
      resp_chk("t1_resp");
      tick();
      chk("t1_idle_resp", ifu_resp_valid, 0);

      // 2: simultaneous requests after reset
      rst_n = 0; tick(); rst_n = 1;
      mem_rdata = 64'hCAFE_0000_0000_0011;
      ifu_req_valid = 1; ifu_addr = 64'h8000_0040;
      lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 64'h8000_0010; lsu_wdt = 2'd3;
      #1;
      chk("t2_lsu_rdy", lsu_req_ready, 1);
      chk("t2_ifu_rdy", ifu_req_ready, 0);
      push(1'b1, 64'hCAFE_0000_0000_0011);
      tick();
      lsu_req_valid = 0;
      chk("t2_issue_addr", mem_addr, 64'h8000_0010);
      chk("t2_issue_rdy", {62'd0, ifu_req_ready, lsu_req_ready}, 0);
      tick();
      resp_chk("t2_lsu_resp");
      chk("t2_resp_rdy", ifu_req_ready, 0);
      tick();
      chk("t2_ifu_rdy2", ifu_req_ready, 1);
      chk("t2_lsu_rdy2", lsu_req_ready, 0);
      mem_rdata = 64'h0000_0000_8765_4321;
      push(1'b0, 64'h0000_0000_8765_4321);
      tick();
      ifu_req_valid = 0;
      chk("t2_ifu_addr", mem_addr, 64'h8000_0040);
      tick();
      resp_chk("t2_ifu_resp");
      tick();

      // 3: LSU store
      mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 64'h8000_0104;
      lsu_wdata = 64'h0000_0000_DEAD_BEEF; lsu_wdt = 2'd2;
      #1;
      chk("t3_rdy", lsu_req_ready, 1);
      push(1'b1, 64'd0);
      tick();
      lsu_req_valid = 0;
      chk("t3_wen", mem_wen, 1);
      chk("t3_ren", mem_ren, 0);
      chk("t3_addr", mem_addr, 64'h8000_0104);
      chk("t3_wdata", mem_wdata, 64'h0000_0000_DEAD_BEEF);
      chk("t3_wdt", mem_wdt, 2);
      chk("t3_mis", misalign, 0);
      tick();
      chk("t3_wen_once", mem_wen, 0);
      resp_chk("t3_resp");
      tick();

      // 4: misaligned Wdt64 load, plus alignment boundary table
      mem_rdata = 64'h0123_4567_89AB_CDEF;
      lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 64'h8000_0004; lsu_wdt = 2'd3;
      push(1'b1, 64'h0123_4567_89AB_CDEF);
      tick();
      lsu_req_valid = 0;
      chk("t4_mis", misalign, 1);
      chk("t4_ren", mem_ren, 1);
      tick();
      chk("t4_mis_clr", misalign, 0);
      resp_chk("t4_resp");
      tick();
      for (int i = 0; i < 5; i++) begin
         lsu_req_valid = 1; lsu_addr = tab_addr[i]; lsu_wdt = tab_wdt[i];
         push(1'b1, 64'h0123_4567_89AB_CDEF);
         tick();
         lsu_req_valid = 0;
         chk($sformatf("t4_tab%0d_mis", i), misalign, tab_mis[i]);
         tick();
         resp_chk($sformatf("t4_tab%0d_resp", i));
         tick();
      end

      // 5: LAT=3 IFU read
      mem_rdata3 = 64'h0000_0000_AAAA_5555;
      ifu_req_valid3 = 1; ifu_addr3 = 64'h8000_0200;
      #1;
      chk("t5_rdy", ifu_req_ready3, 1);
      tick();
      ifu_req_valid3 = 0;
      for (int k = 1; k <= 6; k++) begin
         chk($sformatf("t5_ren_c%0d", k), mem_ren3, (k == 1));
         chk($sformatf("t5_resp_c%0d", k), ifu_resp_valid3, (k == 4));
         if (k == 4) chk("t5_rdata", ifu_rdata3, 64'h0000_0000_AAAA_5555);
         tick();
      end

      // 6: reset during WAIT
      ifu_req_valid3 = 1; ifu_addr3 = 64'h8000_0300;
      tick();
      ifu_req_valid3 = 0;
      chk("t6_issue", mem_ren3, 1);
      tick();
      rst3_n = 0;
      tick();
      rst3_n = 1;
      chk("t6_rst_resp", ifu_resp_valid3, 0);
      chk("t6_rst_ren", mem_ren3, 0);
      chk("t6_rst_addr", mem_addr3, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("t6_no_resp%0d", k), ifu_resp_valid3, 0);
      end
      mem_rdata3 = 64'h0000_0000_0BAD_F00D;
      ifu_req_valid3 = 1; ifu_addr3 = 64'h8000_0400;
      #1;
      chk("t6_fresh_rdy", ifu_req_ready3, 1);
      tick();
      ifu_req_valid3 = 0;
      chk("t6_fresh_addr", mem_addr3, 64'h8000_0400);
      tick(); tick(); tick();
      chk("t6_fresh_resp", ifu_resp_valid3, 1);
      chk("t6_fresh_rdata", ifu_rdata3, 64'h0000_0000_0BAD_F00D);

      chk("sb_drained", 64'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
